// File: rtl/cntr_match_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cntr_match_timer
//  Description : Downstream stage of a 4-bit synchronous counter. Extends the
//                upstream count nibble with an HI_W-bit high section, compares
//                {hi_count, cnt_in} against a programmable match value and
//                emits a one-cycle registered match pulse. A one-shot /
//                periodic FSM (IDLE, RUN, DONE) gates counting and compares.
//
//  Parameters  : HI_W        width of the internal high count (compare width
//                            is HI_W+4)
//
//  Ports       : clk          system clock, all state on rising edge
//                rst          asynchronous reset, active-high
//                cnt_in       upstream count nibble
//                carry_in     upstream carry, one-cycle pulse on 15->0 wrap
//                arm          start / restart pulse
//                clr          synchronous clear to IDLE
//                mode         0 = one-shot, 1 = periodic
//                match_hi     match value, high part
//                match_lo     match value, low part
//                hi_count     extended high count
//                match_pulse  one-cycle pulse per detected match
//                busy         high in RUN
//                done         high in DONE (one-shot complete)
//                ovf          sticky, hi_count wrapped while in RUN
//                cap_val      (CNTR_MATCH_CAPTURE_EN) count captured at match
//                miss         (CNTR_MATCH_CAPTURE_EN) sticky back-to-back match
//
//  Build macro : CNTR_MATCH_CAPTURE_EN adds the cap_val / miss outputs and
//                their logic. Undefined by default.
//
//  Revision    : 1.0  initial release
// ============================================================================
module cntr_match_timer #(
   parameter int HI_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      cnt_in,
   input  logic            carry_in,
   input  logic            arm,
   input  logic            clr,
   input  logic            mode,
   input  logic [HI_W-1:0] match_hi,
   input  logic [3:0]      match_lo,
   output logic [HI_W-1:0] hi_count,
   output logic            match_pulse,
   output logic            busy,
   output logic            done,
   output logic            ovf
`ifdef CNTR_MATCH_CAPTURE_EN
   ,
   output logic [HI_W+3:0] cap_val,
   output logic            miss
`endif
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]      r_state;
   logic [HI_W-1:0] r_hi_count;
   logic            r_match_pulse;
   logic            r_match_seen;
   logic            r_ovf;

   logic            w_run;
   logic            w_eq;
   logic            w_rise;
   logic [HI_W:0]   w_hi_sum;

   assign w_run = (r_state == c_RUN);

   // Compare uses the registered hi_count, so a carry arriving in the same
   // cycle only influences the following cycle's compare.
   assign w_eq = w_run && ({r_hi_count, cnt_in} == {match_hi, match_lo});

   // Only the first cycle of a run of equal compares produces a pulse; a
   // count parked on the match value therefore fires once.
   assign w_rise = w_eq && !r_match_seen;

   // Extra MSB of the sum flags the wrap from all-ones back to zero.
   assign w_hi_sum = {1'b0, r_hi_count} + {{HI_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_IDLE;
         r_hi_count    <= '0;
         r_match_pulse <= 1'b0;
         r_match_seen  <= 1'b0;
         r_ovf         <= 1'b0;
      end else if (clr) begin
         // clr outranks any compare in the same cycle: no pulse follows.
         r_state       <= c_IDLE;
         r_match_pulse <= 1'b0;
         r_match_seen  <= 1'b0;
         r_ovf         <= 1'b0;
      end else if (arm) begin
         // arm restarts from any state, including RUN; a coincident compare
         // is discarded.
         r_state       <= c_RUN;
         r_hi_count    <= '0;
         r_match_pulse <= 1'b0;
         r_match_seen  <= 1'b0;
         r_ovf         <= 1'b0;
      end else begin
         r_match_pulse <= w_rise;
         r_match_seen  <= w_eq;
         case (r_state)
            c_RUN: begin
               if (carry_in) begin
                  r_hi_count <= w_hi_sum[HI_W-1:0];
                  if (w_hi_sum[HI_W]) begin
                     r_ovf <= 1'b1;
                  end
               end
               if (w_eq && !mode) begin
                  r_state <= c_DONE;
               end
            end
            c_IDLE:  r_state <= c_IDLE;
            c_DONE:  r_state <= c_DONE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign hi_count    = r_hi_count;
   assign match_pulse = r_match_pulse;
   assign busy        = w_run;
   assign done        = (r_state == c_DONE);
   assign ovf         = r_ovf;

`ifdef CNTR_MATCH_CAPTURE_EN
   logic [HI_W+3:0] r_cap_val;
   logic            r_miss;

   // Loaded on the same edge that raises match_pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_val <= '0;
      end else if (!clr && !arm && w_rise) begin
         r_cap_val <= {r_hi_count, cnt_in};
      end
   end

   // A compare hit while the previous pulse is still on the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_miss <= 1'b0;
      end else if (clr || arm) begin
         r_miss <= 1'b0;
      end else if (w_eq && r_match_pulse) begin
         r_miss <= 1'b1;
      end
   end

   assign cap_val = r_cap_val;
   assign miss    = r_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cntr_match_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cntr_match_timer
//  Description : Directed self-checking bench for cntr_match_timer. Models a
//                free-running / stallable 4-bit upstream counter whose carry
//                is high in the cycle the count sits at 15.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cntr_match_timer;

   localparam int HI_W = 4;

   logic            clk;
   logic            rst;
   logic [3:0]      cnt_in;
   logic            carry_in;
   logic            arm;
   logic            clr;
   logic            mode;
   logic [HI_W-1:0] match_hi;
   logic [3:0]      match_lo;
   logic [HI_W-1:0] hi_count;
   logic            match_pulse;
   logic            busy;
   logic            done;
   logic            ovf;
`ifdef CNTR_MATCH_CAPTURE_EN
   logic [HI_W+3:0] cap_val;
   logic            miss;
`endif

   cntr_match_timer #(.HI_W(HI_W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .cnt_in      (cnt_in),
      .carry_in    (carry_in),
      .arm         (arm),
      .clr         (clr),
      .mode        (mode),
      .match_hi    (match_hi),
      .match_lo    (match_lo),
      .hi_count    (hi_count),
      .match_pulse (match_pulse),
      .busy        (busy),
      .done        (done),
      .ovf         (ovf)
`ifdef CNTR_MATCH_CAPTURE_EN
      ,
      .cap_val     (cap_val),
      .miss        (miss)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_vec;
   int         n_miss;
   int         pulse_cnt;
   logic [3:0] up_cnt;
   logic       up_en;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: arm/clr are single-cycle pulses, upstream advances after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      arm = 1'b0;
      clr = 1'b0;
      if (match_pulse) pulse_cnt++;
      if (up_en) up_cnt = up_cnt + 4'd1;
      cnt_in   = up_cnt;
      carry_in = up_en && (up_cnt == 4'd15);
   endtask

   // Upstream restarted at 0 and running; first RUN cycle sees combined count 1.
   task automatic arm_from_zero(input logic [7:0] mval, input logic m);
      match_hi = mval[7:4];
      match_lo = mval[3:0];
      mode     = m;
      up_cnt   = 4'd0;
      up_en    = 1'b1;
      cnt_in   = 4'd0;
      carry_in = 1'b0;
      arm      = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec = 0; n_miss = 0; pulse_cnt = 0;
      up_cnt = 4'd0; up_en = 1'b0;
      rst = 1'b1; cnt_in = 4'd0; carry_in = 1'b0; arm = 1'b0; clr = 1'b0;
      mode = 1'b0; match_hi = '0; match_lo = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi_count", hi_count, 0);
      chk("rst_pulse", match_pulse, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // One-shot, match 0x23.
      arm_from_zero(8'h23, 1'b0);
      chk("os_busy_after_arm", busy, 1);
      repeat (34) tick();
      chk("os_hi_before", hi_count, 2);
      chk("os_no_pulse_yet", match_pulse, 0);
      tick();
      chk("os_pulse", match_pulse, 1);
      chk("os_done", done, 1);
      chk("os_busy", busy, 0);
      chk("os_hi", hi_count, 2);
`ifdef CNTR_MATCH_CAPTURE_EN
      chk("os_cap_val", cap_val, 32'h23);
      chk("os_miss", miss, 0);
`endif
      tick();
      chk("os_pulse_single", match_pulse, 0);
      pulse_cnt = 0;
      repeat (300) tick();
      chk("os_no_more_pulses", pulse_cnt, 0);
      chk("os_hi_held", hi_count, 2);
      chk("os_still_done", done, 1);

      // Periodic, match 0x05, 600 upstream counts.
      arm_from_zero(8'h05, 1'b1);
      pulse_cnt = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (i == 199) chk("per_ovf_before_wrap", ovf, 0);
      end
      chk("per_pulse_count", pulse_cnt, 3);
      chk("per_ovf", ovf, 1);
      chk("per_busy", busy, 1);

      // Count parked on the match value.
      arm_from_zero(8'h07, 1'b1);
      repeat (6) tick();
      up_en = 1'b0;
      pulse_cnt = 0;
      repeat (10) tick();
      chk("hold_single_pulse", pulse_cnt, 1);
`ifdef CNTR_MATCH_CAPTURE_EN
      chk("hold_miss", miss, 1);
`endif

      // Match 0x1F with carry in the same cycle.
      arm_from_zero(8'h1F, 1'b0);
      repeat (30) tick();
      chk("pre_hi_count", hi_count, 1);
      chk("pre_no_pulse", match_pulse, 0);
      tick();
      chk("pre_pulse", match_pulse, 1);
      chk("pre_hi_after", hi_count, 2);
      chk("pre_done", done, 1);

      // Reach DONE with ovf set, then re-arm from DONE.
      arm_from_zero(8'h30, 1'b1);
      repeat (200) tick();
      mode = 1'b0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (done) break;
      end
      chk("dn_reached", done, 1);
      chk("dn_hi", hi_count, 3);
      chk("dn_ovf", ovf, 1);
      arm = 1'b1;
      tick();
      chk("rearm_busy", busy, 1);
      chk("rearm_hi", hi_count, 0);
      chk("rearm_ovf", ovf, 0);
      chk("rearm_done", done, 0);

      // arm and clr together in RUN.
      arm = 1'b1;
      clr = 1'b1;
      tick();
      chk("armclr_busy", busy, 0);
      chk("armclr_done", done, 0);

      // Asynchronous reset mid-RUN at hi_count 5.
      arm_from_zero(8'h58, 1'b0);
      repeat (79) tick();
      chk("ar_hi_before", hi_count, 5);
      rst = 1'b1;
      #2;
      chk("ar_hi", hi_count, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_ovf", ovf, 0);
      chk("ar_pulse", match_pulse, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulse_cnt = 0;
      repeat (20) tick();
      chk("ar_no_pulse_after", pulse_cnt, 0);
      chk("ar_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
